// File: rtl/exec_pkg.sv
// Shared definitions for the execute-stage sequencer: opcodes, ALU flag
// bit positions and the sequencer state encoding.
package exec_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_INV   = 3'b001;
  localparam logic [2:0] OP_LOAD  = 3'b010;
  localparam logic [2:0] OP_STORE = 3'b011;
  localparam logic [2:0] OP_NOP   = 3'b100;

  localparam int FLG_C = 0;
  localparam int FLG_Z = 1;
  localparam int FLG_N = 2;
  localparam int FLG_V = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MEM,
    ST_RESP
  } exec_state_e;

  function automatic logic is_mem_op(input logic [2:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/exec_mem_timer.sv
// Wait counter for the memory handshake; expired pulses on the cycle the
// count would reach LIMIT, so the caller leaves MEM after exactly LIMIT cycles.
module exec_mem_timer #(
  parameter int LIMIT = 64,
  parameter int CNT_W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = enable && (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/exec_stage_ctrl.sv
// Execute-stage sequencer: decode handshake, ALU drive, CCR, memory handshake
// and writeback handshake. Optional memory abort timer under EXEC_MEM_TIMEOUT_EN.
module exec_stage_ctrl
  import exec_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int REG_W       = 3,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [DATA_W-1:0] in_src,
  input  logic [DATA_W-1:0] in_dst,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [REG_W-1:0]  in_rd,
  output logic [2:0]        alu_op,
  output logic [DATA_W-1:0] alu_src,
  output logic [DATA_W-1:0] alu_dst,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_flags,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [REG_W-1:0]  out_rd,
  output logic              out_wb_en,
  output logic              out_err,
  output logic [3:0]        ccr
);

  exec_state_e state, state_next;

  logic [2:0]        op_q;
  logic [DATA_W-1:0] src_q, dst_q, wdata_q;
  logic [REG_W-1:0]  rd_q;
  logic [DATA_W-1:0] result_q, addr_q;
  logic              wb_en_q, err_q;
  logic [3:0]        ccr_q;
  logic              mem_abort;

  // Handshake and memory strobes decode straight from state so reset kills them at once.
  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_RESP);
  assign mem_req   = (state == ST_MEM);
  assign mem_we    = mem_req && (op_q == OP_STORE);

  assign alu_op     = op_q;
  assign alu_src    = src_q;
  assign alu_dst    = dst_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign out_result = result_q;
  assign out_rd     = rd_q;
  assign out_wb_en  = wb_en_q;
  assign out_err    = err_q;
  assign ccr        = ccr_q;

`ifdef EXEC_MEM_TIMEOUT_EN
  // An ack suppresses enable, so expired can never beat a same-cycle ack.
  exec_mem_timer #(
    .LIMIT(MEM_TIMEOUT)
  ) u_mem_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == ST_EXEC),
    .enable (mem_req && !mem_ack),
    .expired(mem_abort)
  );
`else
  assign mem_abort = 1'b0;
  wire unused_timeout = (MEM_TIMEOUT != 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (in_valid) state_next = ST_EXEC;
      ST_EXEC: state_next = is_mem_op(op_q) ? ST_MEM : ST_RESP;
      ST_MEM:  if (mem_ack || mem_abort) state_next = ST_RESP;
      ST_RESP: if (out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      wdata_q  <= '0;
      rd_q     <= '0;
      result_q <= '0;
      addr_q   <= '0;
      wb_en_q  <= 1'b0;
      err_q    <= 1'b0;
      ccr_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_q    <= in_op;
            src_q   <= in_src;
            dst_q   <= in_dst;
            wdata_q <= in_wdata;
            rd_q    <= in_rd;
          end
        end
        ST_EXEC: begin
          result_q <= '0;
          wb_en_q  <= 1'b0;
          err_q    <= 1'b0;
          case (op_q)
            OP_ADD: begin
              result_q <= alu_result;
              wb_en_q  <= 1'b1;
              ccr_q    <= alu_flags;
            end
            OP_INV: begin
              result_q     <= alu_result;
              wb_en_q      <= 1'b1;
              ccr_q[FLG_Z] <= alu_flags[FLG_Z];
            end
            OP_LOAD, OP_STORE: addr_q <= alu_result;
            OP_NOP: ;
            default: err_q <= 1'b1;
          endcase
        end
        ST_MEM: begin
          if (mem_ack) begin
            if (op_q == OP_LOAD) begin
              result_q <= mem_rdata;
              wb_en_q  <= 1'b1;
            end else begin
              result_q <= addr_q;
            end
          end else if (mem_abort) begin
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_stage_ctrl.sv
// Scoreboard bench for exec_stage_ctrl: stimulus pushes expected retirements,
// a negedge monitor pops and compares them at each writeback handshake.
module tb_exec_stage_ctrl;
  import exec_pkg::*;

  localparam int TB_TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic [15:0] in_src = '0, in_dst = '0, in_wdata = '0;
  logic [2:0]  in_rd = '0;
  logic [2:0]  alu_op;
  logic [15:0] alu_src, alu_dst;
  logic [15:0] alu_result = '0;
  logic [3:0]  alu_flags = '0;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_result;
  logic [2:0]  out_rd;
  logic        out_wb_en, out_err;
  logic [3:0]  ccr;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] src, dst, wdata;
    logic [2:0]  rd;
    logic [15:0] ares;
    logic [3:0]  aflg;
    int          waits;
    logic [15:0] rdata;
    int          hold;
    int          lat;
    bit          is_mem;
    logic [15:0] e_res;
    bit          chk_res;
    bit          e_wb;
    bit          e_err;
    logic [3:0]  e_ccr;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    bit          chk_res;
    logic [2:0]  rd;
    bit          wb;
    bit          err;
    logic [3:0]  ccr;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   compared = 0;
  int   mismatched = 0;

  exec_stage_ctrl #(
    .DATA_W(16), .REG_W(3), .MEM_TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src(in_src), .in_dst(in_dst), .in_wdata(in_wdata), .in_rd(in_rd),
    .alu_op(alu_op), .alu_src(alu_src), .alu_dst(alu_dst),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_wb_en(out_wb_en), .out_err(out_err), .ccr(ccr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Writeback monitor: one scoreboard entry per completed out handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_retire", 32'(out_rd), 32'hFFFF_FFFF);
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_e.chk_res) checkOutput("out_result", 32'(out_result), 32'(mon_e.res));
        checkOutput("out_rd", 32'(out_rd), 32'(mon_e.rd));
        checkOutput("out_wb_en", 32'(out_wb_en), 32'(mon_e.wb));
        checkOutput("out_err", 32'(out_err), 32'(mon_e.err));
        checkOutput("ccr", 32'(ccr), 32'(mon_e.ccr));
      end
    end
  end

  // Entered and left at posedge+1 with the DUT idle.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    int lat, memcyc, memok, bp_ok, exp_mem;
    e.res = v.e_res; e.chk_res = v.chk_res; e.rd = v.rd;
    e.wb = v.e_wb; e.err = v.e_err; e.ccr = v.e_ccr;
    sb_q.push_back(e);
    in_op = v.op; in_src = v.src; in_dst = v.dst; in_wdata = v.wdata; in_rd = v.rd;
    alu_result = v.ares; alu_flags = v.aflg;
    in_valid = 1'b1;
    checkOutput("accept_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1; memcyc = 0; memok = 0;
    while (!out_valid && lat < 200) begin
      if (mem_req) begin
        memcyc++;
        if (mem_addr == v.ares && mem_we == (v.op == OP_STORE) && mem_wdata == v.wdata) memok++;
        if (v.waits >= 0 && memcyc == v.waits + 1) begin
          mem_ack = 1'b1;
          mem_rdata = v.rdata;
        end
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
      mem_rdata = '0;
      lat++;
    end
    checkOutput("latency", 32'(lat), 32'(v.lat));
    if (v.is_mem) begin
      exp_mem = (v.waits >= 0) ? v.waits + 1 : TB_TIMEOUT;
      checkOutput("mem_cycles", 32'(memcyc), 32'(exp_mem));
      checkOutput("mem_stable", 32'(memok), 32'(exp_mem));
    end
    bp_ok = 0;
    for (int i = 0; i < v.hold; i++) begin
      in_valid = 1'b1;
      if (out_valid && !in_ready) bp_ok++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (v.hold > 0) checkOutput("backpressure_hold", 32'(bp_ok), 32'(v.hold));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("idle_ready", 32'(in_ready), 32'd1);
    checkOutput("idle_no_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic resetMidOp();
    int stray;
    in_op = OP_LOAD; in_src = 16'h0010; in_dst = 16'h0004; in_wdata = '0; in_rd = 3'd2;
    alu_result = 16'h0014; alu_flags = 4'b1111;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_pre_mem_req", 32'(mem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_ccr", 32'(ccr), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid || mem_req) stray++;
    end
    checkOutput("rst_no_stray_output", 32'(stray), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t v;
    rst = 1'b1;
    #12;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_mem_req", 32'(mem_req), 32'd0);
    checkOutput("reset_ccr", 32'(ccr), 32'd0);
    checkOutput("reset_mem_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // op, src, dst, wdata, rd, ares, aflg, waits, rdata, hold, lat, is_mem, e_res, chk_res, e_wb, e_err, e_ccr
    v = '{OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 3'd3, 16'h0000, 4'b0011, -1, 16'h0, 0, 2, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 4'b0011};
    applyStimulus(v);
    resetMidOp();
    v = '{OP_ADD, 16'h0001, 16'h0002, 16'h0000, 3'd1, 16'h0003, 4'b0101, -1, 16'h0, 0, 2, 1'b0, 16'h0003, 1'b1, 1'b1, 1'b0, 4'b0101};
    applyStimulus(v);
    v = '{OP_INV, 16'h0000, 16'hFFFF, 16'h0000, 3'd2, 16'h0000, 4'b0010, -1, 16'h0, 0, 2, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 4'b0111};
    applyStimulus(v);
    v = '{OP_LOAD, 16'h0010, 16'h0004, 16'h0000, 3'd5, 16'h0014, 4'b1111, 3, 16'hBEEF, 0, 6, 1'b1, 16'hBEEF, 1'b1, 1'b1, 1'b0, 4'b0111};
    applyStimulus(v);
    v = '{OP_STORE, 16'h0100, 16'h0020, 16'h1234, 3'd6, 16'h0120, 4'b1000, 0, 16'h0, 5, 3, 1'b1, 16'h0120, 1'b1, 1'b0, 1'b0, 4'b0111};
    applyStimulus(v);
    v = '{OP_NOP, 16'h1111, 16'h2222, 16'h0000, 3'd4, 16'h5555, 4'b1111, -1, 16'h0, 0, 2, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'b0111};
    applyStimulus(v);
    v = '{3'b111, 16'h1111, 16'h2222, 16'h0000, 3'd1, 16'h7777, 4'b1111, -1, 16'h0, 0, 2, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 4'b0111};
    applyStimulus(v);
    v = '{OP_ADD, 16'h7FFF, 16'h0001, 16'h0000, 3'd7, 16'h8000, 4'b1000, -1, 16'h0, 0, 2, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0, 4'b1000};
    applyStimulus(v);
`ifdef EXEC_MEM_TIMEOUT_EN
    v = '{OP_LOAD, 16'h0200, 16'h0002, 16'h0000, 3'd3, 16'h0202, 4'b0000, -1, 16'h0, 0, TB_TIMEOUT + 2, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 4'b1000};
    applyStimulus(v);
`endif

    repeat (2) @(posedge clk);
    checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
